// File: rtl/bc1_pkg.sv
// Shared BC1 definitions: block field layout, encoder FSM states, RGB565 helpers.
// Optional macro BC1_ENC_ROUND_EN selects rounding (saturating) quantization.
package bc1_pkg;

  localparam int unsigned C1_LSB = 48;
  localparam int unsigned C0_LSB = 32;
  localparam int unsigned IDX_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ENDPT,
    ST_INDEX,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic rgb888_t expand565(input rgb565_t c);
    rgb888_t e;
    e.r = {c.r, c.r[4:2]};
    e.g = {c.g, c.g[5:4]};
    e.b = {c.b, c.b[4:2]};
    return e;
  endfunction

  function automatic rgb565_t quant565(input rgb888_t c);
    rgb565_t q;
`ifdef BC1_ENC_ROUND_EN
    q.r = (c.r > 8'd251) ? 5'd31 : 5'((c.r + 8'd4) >> 3);
    q.g = (c.g > 8'd253) ? 6'd63 : 6'((c.g + 8'd2) >> 2);
    q.b = (c.b > 8'd251) ? 5'd31 : 5'((c.b + 8'd4) >> 3);
`else
    q.r = c.r[7:3];
    q.g = c.g[7:2];
    q.b = c.b[7:3];
`endif
    return q;
  endfunction

endpackage

// File: rtl/bc1_palette_sel.sv
// Nearest-palette selector: SAD over RGB, lowest index wins ties; entry 3 only in 4-color mode.
module bc1_palette_sel (
  input  logic [23:0] texel_i,
  input  logic [23:0] p0_i,
  input  logic [23:0] p1_i,
  input  logic [23:0] p2_i,
  input  logic [23:0] p3_i,
  input  logic        mode4_i,
  output logic [1:0]  idx_o
);

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [9:0] sad(input logic [23:0] a, input logic [23:0] b);
    return {2'b00, absdiff(a[23:16], b[23:16])}
         + {2'b00, absdiff(a[15:8],  b[15:8])}
         + {2'b00, absdiff(a[7:0],   b[7:0])};
  endfunction

  logic [9:0] d0, d1, d2, d3, best;

  always_comb begin
    d0    = sad(texel_i, p0_i);
    d1    = sad(texel_i, p1_i);
    d2    = sad(texel_i, p2_i);
    d3    = sad(texel_i, p3_i);
    idx_o = 2'd0;
    best  = d0;
    if (d1 < best) begin
      best  = d1;
      idx_o = 2'd1;
    end
    if (d2 < best) begin
      best  = d2;
      idx_o = 2'd2;
    end
    if (mode4_i && (d3 < best)) begin
      idx_o = 2'd3;
    end
  end

endmodule

// File: rtl/bc1_encode.sv
// Sequential BC1 block encoder: scan for bounding box, build palette, pick indices one texel per cycle.
// Build option BC1_ENC_ROUND_EN (in bc1_pkg) switches endpoint quantization to rounding.
module bc1_encode
  import bc1_pkg::*;
#(
  parameter int unsigned ALPHA_THRESH = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_pixels,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block
);

  localparam logic [8:0] THR = 9'(ALPHA_THRESH);

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [511:0]   pix_q;
  rgb888_t        mn_q, mx_q;
  logic           any_t_q, any_o_q;
  rgb565_t        c0_q, c1_q;
  logic           mode4_q, allt_q;
  rgb888_t        p0_q, p1_q, p2_q, p3_q;
  logic [IDX_W-1:0] idx_q;
  logic           in_ready_q, out_valid_q;
  logic [63:0]    out_block_q;

  logic [31:0]    texel;
  rgb888_t        tx;
  logic           transp;
  rgb565_t        cmax, cmin, c0_d, c1_d;
  logic           mode4_d;
  rgb888_t        e0, e1, p2_d, p3_d;
  logic [1:0]     sel_idx, idx_d;

  function automatic rgb888_t mix3(input rgb888_t a, input rgb888_t b);
    rgb888_t m;
    m.r = 8'((10'd2 * 10'(a.r) + 10'(b.r)) / 10'd3);
    m.g = 8'((10'd2 * 10'(a.g) + 10'(b.g)) / 10'd3);
    m.b = 8'((10'd2 * 10'(a.b) + 10'(b.b)) / 10'd3);
    return m;
  endfunction

  function automatic rgb888_t avg2(input rgb888_t a, input rgb888_t b);
    rgb888_t m;
    m.r = 8'((9'(a.r) + 9'(b.r)) >> 1);
    m.g = 8'((9'(a.g) + 9'(b.g)) >> 1);
    m.b = 8'((9'(a.b) + 9'(b.b)) >> 1);
    return m;
  endfunction

  assign texel  = pix_q[{cnt_q, 5'd0} +: 32];
  assign tx     = rgb888_t'(texel[23:0]);
  assign transp = {1'b0, texel[31:24]} < THR;

  always_comb begin
    cmax = quant565(mx_q);
    cmin = quant565(mn_q);
    if (!any_o_q) begin
      c0_d = '0;
      c1_d = '0;
    end else if (!any_t_q) begin
      c0_d = cmax;
      c1_d = cmin;
    end else begin
      c0_d = cmin;
      c1_d = cmax;
    end
    mode4_d = c0_d > c1_d;
    e0      = expand565(c0_d);
    e1      = expand565(c1_d);
    if (mode4_d) begin
      p2_d = mix3(e0, e1);
      p3_d = mix3(e1, e0);
    end else begin
      p2_d = avg2(e0, e1);
      p3_d = '0;
    end
  end

  bc1_palette_sel u_sel (
    .texel_i (tx),
    .p0_i    (p0_q),
    .p1_i    (p1_q),
    .p2_i    (p2_q),
    .p3_i    (p3_q),
    .mode4_i (mode4_q),
    .idx_o   (sel_idx)
  );

  assign idx_d = (allt_q || (transp && !mode4_q)) ? 2'd3 : sel_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pix_q       <= '0;
      mn_q        <= '1;
      mx_q        <= '0;
      any_t_q     <= 1'b0;
      any_o_q     <= 1'b0;
      c0_q        <= '0;
      c1_q        <= '0;
      mode4_q     <= 1'b0;
      allt_q      <= 1'b0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            pix_q      <= in_pixels;
            mn_q       <= '1;
            mx_q       <= '0;
            any_t_q    <= 1'b0;
            any_o_q    <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (transp) begin
            any_t_q <= 1'b1;
          end else begin
            any_o_q <= 1'b1;
            mn_q.r  <= (tx.r < mn_q.r) ? tx.r : mn_q.r;
            mn_q.g  <= (tx.g < mn_q.g) ? tx.g : mn_q.g;
            mn_q.b  <= (tx.b < mn_q.b) ? tx.b : mn_q.b;
            mx_q.r  <= (tx.r > mx_q.r) ? tx.r : mx_q.r;
            mx_q.g  <= (tx.g > mx_q.g) ? tx.g : mx_q.g;
            mx_q.b  <= (tx.b > mx_q.b) ? tx.b : mx_q.b;
          end
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= ST_ENDPT;
        end
        ST_ENDPT: begin
          c0_q    <= c0_d;
          c1_q    <= c1_d;
          mode4_q <= mode4_d;
          allt_q  <= !any_o_q;
          p0_q    <= e0;
          p1_q    <= e1;
          p2_q    <= p2_d;
          p3_q    <= p3_d;
          state_q <= ST_INDEX;
        end
        ST_INDEX: begin
          idx_q[{cnt_q, 1'b0} +: 2] <= idx_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle publishes the block; afterwards hold until the consumer takes it.
          if (!out_valid_q) begin
            out_valid_q                   <= 1'b1;
            out_block_q[C1_LSB +: 16]     <= c1_q;
            out_block_q[C0_LSB +: 16]     <= c0_q;
            out_block_q[IDX_W-1:0]        <= idx_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;

endmodule

// File: tb/tb_bc1_encode.sv
// Self-checking bench for bc1_encode: directed vectors, backpressure, reset abort, random blocks.
module tb_bc1_encode;

  localparam int THR = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_pixels;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_block;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bc1_encode #(.ALPHA_THRESH(THR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixels (in_pixels),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int quant(input int v, input int bits);
    int r;
`ifdef BC1_ENC_ROUND_EN
    r = (v + (1 << (7 - bits))) >> (8 - bits);
    if (r > (1 << bits) - 1) r = (1 << bits) - 1;
`else
    r = v >> (8 - bits);
`endif
    return r;
  endfunction

  function automatic int expand(input int c, input int bits);
    return (c << (8 - bits)) | (c >> (2 * bits - 8));
  endfunction

  // Reference encoder built directly from the BC1 rules with integer arithmetic.
  function automatic logic [63:0] model(input logic [511:0] px);
    int a[16];
    int ch[16][3];
    int mn[3], mx[3], c0[3], c1[3], e0[3], e1[3];
    int pal[4][3];
    int bits[3];
    int v0, v1, nleg, best, bestd, d, id;
    bit anyt, anyo, four;
    logic [31:0] idx;
    logic [15:0] w0, w1;
    bits[0] = 5; bits[1] = 6; bits[2] = 5;
    anyt = 0; anyo = 0; idx = '0;
    for (int k = 0; k < 3; k++) begin mn[k] = 255; mx[k] = 0; end
    for (int i = 0; i < 16; i++) begin
      a[i]     = int'(px[32*i+24 +: 8]);
      ch[i][0] = int'(px[32*i+16 +: 8]);
      ch[i][1] = int'(px[32*i+8  +: 8]);
      ch[i][2] = int'(px[32*i    +: 8]);
      if (a[i] < THR) anyt = 1;
      else begin
        anyo = 1;
        for (int k = 0; k < 3; k++) begin
          if (ch[i][k] < mn[k]) mn[k] = ch[i][k];
          if (ch[i][k] > mx[k]) mx[k] = ch[i][k];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!anyo) begin c0[k] = 0; c1[k] = 0; end
      else if (!anyt) begin c0[k] = quant(mx[k], bits[k]); c1[k] = quant(mn[k], bits[k]); end
      else begin c0[k] = quant(mn[k], bits[k]); c1[k] = quant(mx[k], bits[k]); end
      e0[k] = expand(c0[k], bits[k]);
      e1[k] = expand(c1[k], bits[k]);
    end
    v0 = c0[0] * 2048 + c0[1] * 32 + c0[2];
    v1 = c1[0] * 2048 + c1[1] * 32 + c1[2];
    four = v0 > v1;
    for (int k = 0; k < 3; k++) begin
      pal[0][k] = e0[k];
      pal[1][k] = e1[k];
      if (four) begin
        pal[2][k] = (2 * e0[k] + e1[k]) / 3;
        pal[3][k] = (e0[k] + 2 * e1[k]) / 3;
      end else begin
        pal[2][k] = (e0[k] + e1[k]) / 2;
        pal[3][k] = 0;
      end
    end
    nleg = four ? 4 : 3;
    for (int i = 0; i < 16; i++) begin
      if (!anyo || (a[i] < THR && !four)) id = 3;
      else begin
        best = 0; bestd = 100000;
        for (int p = 0; p < nleg; p++) begin
          d = 0;
          for (int k = 0; k < 3; k++) d += (ch[i][k] > pal[p][k]) ? ch[i][k] - pal[p][k] : pal[p][k] - ch[i][k];
          if (d < bestd) begin bestd = d; best = p; end
        end
        id = best;
      end
      idx[2*i +: 2] = 2'(id);
    end
    w0 = 16'(v0);
    w1 = 16'(v1);
    return {w1, w0, idx};
  endfunction

  function automatic logic [511:0] fill(input logic [31:0] even, input logic [31:0] odd);
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = (i % 2 == 0) ? even : odd;
    return p;
  endfunction

  function automatic logic [511:0] gen_block(input int kind);
    logic [511:0] p;
    logic [31:0] t;
    logic [7:0] lv[3];
    lv[0] = 8'h00; lv[1] = 8'h80; lv[2] = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      t = $urandom;
      case (kind)
        0: t[31:24] = 8'hFF;
        1: t[31:24] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
        2: t[31:24] = 8'($urandom_range(0, 127));
        default: begin
          t[31:24] = 8'hFF;
          t[23:16] = lv[$urandom_range(0, 2)];
          t[15:8]  = lv[$urandom_range(0, 2)];
          t[7:0]   = lv[$urandom_range(0, 2)];
        end
      endcase
      p[32*i +: 32] = t;
    end
    return p;
  endfunction

  // Caller sits at #1 after a rising edge; returns in the same phase.
  task automatic run_block(input logic [511:0] px, input logic [63:0] exp, input string tag);
    int n;
    in_pixels = px;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, 64'(n), 64'd34);
    check({tag, "_block"}, out_block, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_handshake"}, {62'b0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] pa, pb, pc;
    int n, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixels = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_block", out_block, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_block(fill(32'hFFFF0000, 32'hFFFF0000), 64'hF800_F800_0000_0000, "solid_red");
    pa = fill(32'hFF000000, 32'hFFFFFFFF);
    run_block(pa, 64'h0000_FFFF_1111_1111, "checker4");
    pa[32*15 +: 32] = 32'h00FFFFFF;
    run_block(pa, 64'hFFFF_0000_C444_4444, "checker3");
    run_block(fill(32'h00123456, 32'h007F7F7F), 64'h0000_0000_FFFF_FFFF, "all_transp");

    // Backpressure with a second block waiting on in_valid.
    pa = gen_block(1);
    pb = gen_block(0);
    in_pixels = pa; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_pixels = pb;
    n = 0;
    while (!out_valid && n < 100) begin
      check("bp_busy_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1; n++;
    end
    check("bp_latency", 64'(n), 64'd34);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_block", out_block, model(pa));
      check("bp_hold_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_handshake", {62'b0, out_valid, in_ready}, 64'd1);
    @(posedge clk); #1;
    check("bp_second_accept", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("bp2_latency", 64'(n), 64'd34);
    check("bp2_block", out_block, model(pb));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp2_handshake", {62'b0, out_valid, in_ready}, 64'd1);

    // Reset during SCAN cycle 5.
    in_pixels = gen_block(0); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_abort", {62'b0, out_valid, in_ready}, 64'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_no_partial", 64'(seen), 64'd0);
    pc = fill(32'hFF070707, 32'hFF070707);
    run_block(pc, model(pc), "post_rst");

    for (int r = 0; r < 16; r++) begin
      pa = gen_block(r % 4);
      run_block(pa, model(pa), $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
